// File: rtl/speed_rx_pkg.sv
// Shared types and constants for the speed-frame receiver.
// Optional macro SPEED_RX_PARITY_EN selects 8E1 framing (adds the PARITY bit state).
package speed_rx_pkg;

`ifdef SPEED_RX_PARITY_EN
  typedef enum logic [2:0] {
    BIT_IDLE, BIT_START, BIT_DATA, BIT_PARITY, BIT_STOP, BIT_BREAK
  } bit_state_t;
  localparam int BITS_PER_CHAR = 11;
`else
  typedef enum logic [2:0] {
    BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP, BIT_BREAK
  } bit_state_t;
  localparam int BITS_PER_CHAR = 10;
`endif

  typedef enum logic {FR_WAIT_HI, FR_WAIT_LO} frame_state_t;

  localparam logic [1:0] HDR_MARK = 2'b10;

endpackage

// File: rtl/speed_frame_rx_if.sv
// Bus between the speed-frame receiver (master) and whatever drives its line and
// consumes its speed words (slave); also carries both FSM states for observation.
interface speed_frame_rx_if #(
    parameter int WIDTH_SPEED = 14
);
    import speed_rx_pkg::*;

    // speed_valid is a one-cycle strobe with no ready: the consumer takes speed in
    // that cycle; speed then holds until the next strobe. frame_err is a lone strobe.
    logic                   serial_data_in;
    logic [WIDTH_SPEED-1:0] speed;
    logic                   speed_valid;
    logic                   frame_err;
    logic                   busy;
    bit_state_t             bit_state;
    frame_state_t           frame_state;

    modport master (
        input  serial_data_in,
        output speed, speed_valid, frame_err, busy, bit_state, frame_state
    );

    modport slave (
        output serial_data_in,
        input  speed, speed_valid, frame_err, busy, bit_state, frame_state
    );

endinterface

// File: rtl/uart_rx_core.sv
// Line synchroniser and bit FSM: turns the serial line into bytes, one strobe per
// good character, one char_err strobe per bad stop bit (or bad parity when enabled).
module uart_rx_core
    import speed_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       char_err,
    output bit_state_t state_dbg
);
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync;
    logic          rx_s, rx_d;
    bit_state_t    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n, data_n;
    logic          byte_valid_n, char_err_n;
`ifdef SPEED_RX_PARITY_EN
    logic          parity_ok, parity_ok_n;
`endif

    assign rx_s      = sync[1];
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync       <= 2'b11;
            rx_d       <= 1'b1;
            state      <= BIT_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data_byte  <= '0;
            byte_valid <= 1'b0;
            char_err   <= 1'b0;
`ifdef SPEED_RX_PARITY_EN
            parity_ok  <= 1'b1;
`endif
        end else begin
            sync       <= {sync[0], rx};
            rx_d       <= rx_s;
            state      <= state_n;
            timer      <= timer_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            data_byte  <= data_n;
            byte_valid <= byte_valid_n;
            char_err   <= char_err_n;
`ifdef SPEED_RX_PARITY_EN
            parity_ok  <= parity_ok_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer + TW'(1);
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        data_n       = data_byte;
        byte_valid_n = 1'b0;
        char_err_n   = 1'b0;
`ifdef SPEED_RX_PARITY_EN
        parity_ok_n  = parity_ok;
`endif
        case (state)
            BIT_IDLE: begin
                timer_n = '0;
                if (rx_d && !rx_s) state_n = BIT_START;
            end
            BIT_START: begin
                // Re-check the line mid start bit so short glitches are ignored.
                if (timer == HALF_LAST) begin
                    timer_n   = '0;
                    bit_cnt_n = '0;
                    state_n   = rx_s ? BIT_IDLE : BIT_DATA;
                end
            end
            BIT_DATA: begin
                if (timer == FULL_LAST) begin
                    timer_n   = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
`ifdef SPEED_RX_PARITY_EN
                    if (bit_cnt == 3'd7) state_n = BIT_PARITY;
`else
                    if (bit_cnt == 3'd7) state_n = BIT_STOP;
`endif
                end
            end
`ifdef SPEED_RX_PARITY_EN
            BIT_PARITY: begin
                if (timer == FULL_LAST) begin
                    timer_n     = '0;
                    parity_ok_n = ~(^shift ^ rx_s);
                    state_n     = BIT_STOP;
                end
            end
`endif
            BIT_STOP: begin
                if (timer == FULL_LAST) begin
                    timer_n = '0;
                    if (rx_s) begin
                        state_n = BIT_IDLE;
`ifdef SPEED_RX_PARITY_EN
                        if (parity_ok) begin
                            byte_valid_n = 1'b1;
                            data_n       = shift;
                        end else begin
                            char_err_n = 1'b1;
                        end
`else
                        byte_valid_n = 1'b1;
                        data_n       = shift;
`endif
                    end else begin
                        char_err_n = 1'b1;
                        state_n    = BIT_BREAK;
                    end
                end
            end
            BIT_BREAK: begin
                // A held-low line is one error, not a stream of false start bits.
                timer_n = '0;
                if (rx_s) state_n = BIT_IDLE;
            end
            default: state_n = BIT_IDLE;
        endcase
    end

endmodule

// File: rtl/speed_frame_rx.sv
// Speed-frame receiver top: reassembles header/low byte pairs from uart_rx_core into
// a speed word, with an inter-byte timeout. SPEED_RX_PARITY_EN enables 8E1 framing.
module speed_frame_rx
    import speed_rx_pkg::*;
#(
    parameter int SYS_FREQ      = 50000000,
    parameter int BAUD          = 9600,
    parameter int WIDTH_SPEED   = 14,
    parameter int TIMEOUT_BYTES = 4
) (
    input logic             clk,
    input logic             reset,
    speed_frame_rx_if.master bus
);
    localparam int CLKS_PER_BIT = SYS_FREQ / BAUD;
    localparam int HI_W         = WIDTH_SPEED - 8;
    localparam int TO_LIMIT     = TIMEOUT_BYTES * BITS_PER_CHAR * CLKS_PER_BIT;
    localparam int CW           = $clog2(TO_LIMIT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LIMIT);

    logic [7:0]             data_byte;
    logic                   byte_valid, char_err;
    frame_state_t           state, state_n;
    logic [HI_W-1:0]        hi, hi_n;
    logic [CW-1:0]          to_cnt, to_cnt_n;
    logic [WIDTH_SPEED-1:0] speed_n;
    logic                   speed_valid_n, frame_err_n;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk        (clk),
        .reset      (reset),
        .rx         (bus.serial_data_in),
        .data_byte  (data_byte),
        .byte_valid (byte_valid),
        .char_err   (char_err),
        .state_dbg  (bus.bit_state)
    );

    assign bus.frame_state = state;
    assign bus.busy        = (bus.bit_state != BIT_IDLE) || (state == FR_WAIT_LO);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= FR_WAIT_HI;
            hi              <= '0;
            to_cnt          <= '0;
            bus.speed       <= '0;
            bus.speed_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            state           <= state_n;
            hi              <= hi_n;
            to_cnt          <= to_cnt_n;
            bus.speed       <= speed_n;
            bus.speed_valid <= speed_valid_n;
            bus.frame_err   <= frame_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        hi_n          = hi;
        to_cnt_n      = to_cnt;
        speed_n       = bus.speed;
        speed_valid_n = 1'b0;
        frame_err_n   = 1'b0;
        case (state)
            FR_WAIT_HI: begin
                if (byte_valid) begin
                    if (data_byte[7:6] == HDR_MARK) begin
                        hi_n     = data_byte[HI_W-1:0];
                        to_cnt_n = '0;
                        state_n  = FR_WAIT_LO;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else if (char_err) begin
                    frame_err_n = 1'b1;
                end
            end
            FR_WAIT_LO: begin
                // A completed low byte wins over a timeout landing in the same cycle.
                if (byte_valid) begin
                    speed_n       = {hi, data_byte};
                    speed_valid_n = 1'b1;
                    state_n       = FR_WAIT_HI;
                end else if (char_err || (to_cnt == TO_LAST)) begin
                    frame_err_n = 1'b1;
                    state_n     = FR_WAIT_HI;
                end else begin
                    to_cnt_n = to_cnt + CW'(1);
                end
            end
            default: state_n = FR_WAIT_HI;
        endcase
    end

endmodule

// File: tb/tb_speed_frame_rx.sv
// Randomized and directed bench for speed_frame_rx at a short bit time (16 clk/bit),
// scored against a byte-level frame model of the link protocol.
module tb_speed_frame_rx;
  localparam int SYS_FREQ      = 1600000;
  localparam int BAUD          = 100000;
  localparam int CPB           = SYS_FREQ / BAUD;
  localparam int W             = 14;
  localparam int TIMEOUT_BYTES = 4;
`ifdef SPEED_RX_PARITY_EN
  localparam int CHAR_BITS = 11;
`else
  localparam int CHAR_BITS = 10;
`endif
  localparam int TO_CYCLES = TIMEOUT_BYTES * CHAR_BITS * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;

  speed_frame_rx_if #(.WIDTH_SPEED(W)) bus ();

  speed_frame_rx #(
    .SYS_FREQ(SYS_FREQ), .BAUD(BAUD), .WIDTH_SPEED(W), .TIMEOUT_BYTES(TIMEOUT_BYTES)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  int exp_err = 0;
  int fe_count = 0;
  int sv_count = 0;
  bit pend = 1'b0;
  logic [5:0] pend_hi = '0;
  logic [W-1:0] last_speed = '0;
  logic [W-1:0] prev_speed = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // frame-level reference: header byte 10xxxxxx opens a frame, next byte closes it
  task automatic model_byte(input logic [7:0] b, input bit good_stop);
    if (!good_stop) begin
      exp_err++;
      pend = 1'b0;
    end else if (!pend) begin
      if (b[7:6] == 2'b10) begin
        pend    = 1'b1;
        pend_hi = b[5:0];
      end else begin
        exp_err++;
      end
    end else begin
      last_speed = {pend_hi, b};
      exp_q.push_back(last_speed);
      pend = 1'b0;
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input logic v);
    bus.serial_data_in = v;
    idle(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop, input int low_hold);
    model_byte(b, good_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SPEED_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(good_stop);
    if (!good_stop) begin
      bus.serial_data_in = 1'b0;
      idle(low_hold * CPB);
      bus.serial_data_in = 1'b1;
      idle(4);
    end
    bus.serial_data_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input int gap);
    send_byte(b0, 1'b1, 0);
    idle(gap);
    send_byte(b1, 1'b1, 0);
  endtask

  task automatic scen_check(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 4 * CHAR_BITS * CPB) begin
      @(negedge clk);
      n++;
    end
    idle(4);
    check({tag, "_quiet"}, bus.busy, 0);
    check({tag, "_errs"}, fe_count, exp_err);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // output monitor
  always @(negedge clk) begin
    if (reset) begin
      prev_speed = bus.speed;
    end else begin
      check("excl", bus.speed_valid & bus.frame_err, 0);
      if (bus.speed_valid) begin
        sv_count++;
        check("sv_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("speed", bus.speed, exp_q.pop_front());
      end else begin
        check("speed_hold", bus.speed, prev_speed);
      end
      if (bus.frame_err) fe_count++;
      prev_speed = bus.speed;
    end
  end

  initial begin
    int wait_c;
    int sv_before;
    bit seen;
    logic [7:0] b0, b1;
    int r;

    bus.serial_data_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_speed", bus.speed, 0);
    check("rst_sv", bus.speed_valid, 0);
    check("rst_fe", bus.frame_err, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);

    // 1: basic frame, busy while the frame is half received
    send_byte(8'h80, 1'b1, 0);
    @(negedge clk);
    check("busy_mid_frame", bus.busy, 1);
    send_byte(8'hE1, 1'b1, 0);
    scen_check("t1");
    check("t1_speed", bus.speed, 225);

    // 2: extremes and hold
    send_frame(8'hBF, 8'hFF, 0);
    idle(3 * CPB);
    check("t2_max", bus.speed, 16383);
    send_frame(8'h80, 8'h00, 0);
    scen_check("t2");

    // 3: bad header byte
    send_byte(8'h41, 1'b1, 0);
    idle(4);
    @(negedge clk);
    check("t3_busy", bus.busy, 0);
    scen_check("t3");

    // 4: bad stop bit, line held low, then recover
    send_byte(8'h80, 1'b0, 3);
    scen_check("t4a");
    send_frame(8'h81, 8'h02, 0);
    scen_check("t4");
    check("t4_speed", bus.speed, 258);

    // 5: header then silence -> timeout
    send_byte(8'h80, 1'b1, 0);
    seen = 1'b0;
    for (wait_c = 0; wait_c < TO_CYCLES + 4 * CPB; wait_c++) begin
      @(negedge clk);
      if (bus.frame_err) begin seen = 1'b1; break; end
    end
    exp_err++;
    pend = 1'b0;
    check("t5_fired", seen, 1);
    check("t5_window", (wait_c >= TO_CYCLES - CPB) && (wait_c <= TO_CYCLES + CPB), 1);
    scen_check("t5a");
    send_frame(8'h80, 8'h05, 0);
    scen_check("t5");
    check("t5_speed", bus.speed, 5);

    // random traffic
    for (int k = 0; k < 24; k++) begin
      r  = $urandom_range(0, 9);
      b1 = 8'($urandom_range(0, 255));
      if (r < 2) begin
        b0 = {2'($urandom_range(0, 2)), 6'($urandom_range(0, 63))};
        if (b0[7:6] == 2'b10) b0[7:6] = 2'b11;
        send_byte(b0, 1'b1, 0);
      end else begin
        b0 = {2'b10, 6'($urandom_range(0, 63))};
        send_byte(b0, 1'b1, 0);
        idle($urandom_range(0, 2 * CPB));
        send_byte(b1, (r != 9), $urandom_range(0, 2));
      end
      idle($urandom_range(0, CPB));
    end
    scen_check("rand");
    check("rand_speed", bus.speed, last_speed);

    // 6: short glitch on idle line
    sv_before = sv_count;
    bus.serial_data_in = 1'b0;
    idle(5);
    bus.serial_data_in = 1'b1;
    idle(2 * CHAR_BITS * CPB);
    check("t6_glitch_sv", sv_count, sv_before);
    scen_check("t6a");

    // 6: reset mid byte1
    send_frame(8'h9A, 8'h5C, 0);
    scen_check("t6b");
    send_byte(8'h83, 1'b1, 0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.serial_data_in = 1'b1;
    pend = 1'b0;
    last_speed = '0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_speed", bus.speed, 0);
    check("t6_rst_sv", bus.speed_valid, 0);
    check("t6_rst_fe", bus.frame_err, 0);
    check("t6_rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sv_before = sv_count;
    idle(2 * CHAR_BITS * CPB);
    check("t6_no_sv", sv_count, sv_before);
    check("t6_speed_zero", bus.speed, 0);
    scen_check("t6c");
    send_frame(8'hA0, 8'h10, 0);
    scen_check("t6");
    check("t6_speed", bus.speed, 16'h2010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
